// File: rtl/turn_decoder.sv
// turn_decoder: follows a line-following bot around a fixed 30-node arena.
// Each relative turn is combined with the current absolute heading, and the
// adjacency table is then used to find the next node. Every node the bot
// visits is recorded in a show-ahead FIFO that the CPU can read back.
module turn_decoder #(
    parameter logic [4:0] START_NODE = 5'd0,
    parameter logic [1:0] START_HDG  = 2'd0,
    parameter int         LOG_DEPTH  = 32
) (
    input  logic       clk_3125KHz,
    input  logic       rst_n,
    input  logic       CPU_start,
    input  logic       turn_valid,
    input  logic [1:0] turn_taken,
    input  logic       node_flag,
    input  logic       log_rd,
    output logic [4:0] realtime_pos,
    output logic [1:0] heading,
    output logic [4:0] next_node,
    output logic       next_valid,
    output logic       path_err,
    output logic [4:0] log_data,
    output logic       log_empty,
    output logic       log_full,
    output logic [5:0] log_count
);

    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [5:0]    DEPTH_CNT = 6'(LOG_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(LOG_DEPTH - 1);
    localparam logic [4:0]    NE        = 5'd31;   // no edge in this direction

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_TURN   = 3'd1;
    localparam logic [2:0] S_LOOKUP      = 3'd2;
    localparam logic [2:0] S_WAIT_ARRIVE = 3'd3;
    localparam logic [2:0] S_ERROR       = 3'd4;

    // Arena adjacency, one row per node packed as {N, E, S, W}.
    function automatic logic [19:0] adj_row(input logic [4:0] node);
        case (node)
            5'd0:  adj_row = {5'd1,  NE,     NE,     NE    };
            5'd1:  adj_row = {5'd2,  5'd29,  5'd0,   NE    };
            5'd2:  adj_row = {5'd3,  NE,     5'd1,   NE    };
            5'd3:  adj_row = {5'd4,  NE,     5'd2,   NE    };
            5'd4:  adj_row = {5'd5,  NE,     5'd3,   NE    };
            5'd5:  adj_row = {5'd6,  NE,     5'd4,   NE    };
            5'd6:  adj_row = {5'd7,  NE,     5'd5,   NE    };
            5'd7:  adj_row = {5'd8,  NE,     5'd6,   NE    };
            5'd8:  adj_row = {5'd9,  NE,     5'd7,   NE    };
            5'd9:  adj_row = {NE,    5'd10,  5'd8,   NE    };
            5'd10: adj_row = {NE,    5'd11,  NE,     5'd9  };
            5'd11: adj_row = {NE,    5'd12,  NE,     5'd10 };
            5'd12: adj_row = {NE,    5'd13,  NE,     5'd11 };
            5'd13: adj_row = {NE,    5'd14,  NE,     5'd12 };
            5'd14: adj_row = {NE,    5'd15,  NE,     5'd13 };
            5'd15: adj_row = {NE,    5'd16,  NE,     5'd14 };
            5'd16: adj_row = {NE,    5'd17,  NE,     5'd15 };
            5'd17: adj_row = {NE,    5'd18,  NE,     5'd16 };
            5'd18: adj_row = {NE,    5'd19,  NE,     5'd17 };
            5'd19: adj_row = {5'd28, NE,     NE,     5'd18 };
            5'd20: adj_row = {NE,    5'd21,  5'd29,  NE    };
            5'd21: adj_row = {NE,    5'd22,  NE,     5'd20 };
            5'd22: adj_row = {NE,    5'd23,  NE,     5'd21 };
            5'd23: adj_row = {NE,    5'd24,  NE,     5'd22 };
            5'd24: adj_row = {NE,    5'd25,  NE,     5'd23 };
            5'd25: adj_row = {NE,    5'd26,  NE,     5'd24 };
            5'd26: adj_row = {NE,    5'd27,  NE,     5'd25 };
            5'd27: adj_row = {NE,    5'd28,  NE,     5'd26 };
            5'd28: adj_row = {NE,    NE,     5'd19,  5'd27 };
            5'd29: adj_row = {5'd20, NE,     NE,     5'd1  };
            default: adj_row = {NE, NE, NE, NE};
        endcase
    endfunction

    // Select the neighbour in absolute direction hdg from a packed row.
    function automatic logic [4:0] adj_pick(input logic [19:0] row, input logic [1:0] hdg);
        case (hdg)
            2'd0:    adj_pick = row[19:15];
            2'd1:    adj_pick = row[14:10];
            2'd2:    adj_pick = row[9:5];
            default: adj_pick = row[4:0];
        endcase
    endfunction

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + 1'b1;
        end
    endfunction

    logic [2:0]    state_q, state_d;
    logic [4:0]    pos_q, pos_d;
    logic [1:0]    hdg_q, hdg_d;
    logic [4:0]    next_node_q, next_node_d;
    logic          next_valid_q, next_valid_d;
    logic          path_err_q, path_err_d;
    logic          push_s;
    logic [4:0]    push_data_s;
    logic [4:0]    lookup_s;

    logic [4:0]    mem_q [LOG_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [5:0]    count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic [4:0]    log_data_q, log_data_d;
    logic          do_push_s, do_pop_s;

    assign lookup_s = adj_pick(adj_row(pos_q), hdg_q);

    // Tracking FSM: next-state and datapath updates, plus the log push request.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        hdg_d        = hdg_q;
        next_node_d  = next_node_q;
        next_valid_d = next_valid_q;
        path_err_d   = path_err_q;
        push_s       = 1'b0;
        push_data_s  = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (CPU_start) begin
                    pos_d       = START_NODE;
                    hdg_d       = START_HDG;
                    push_s      = 1'b1;
                    push_data_s = START_NODE;
                    state_d     = S_WAIT_TURN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_TURN: begin
                if (turn_valid) begin
                    hdg_d   = hdg_q + turn_taken;   // 2-bit wrap gives mod 4
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_WAIT_TURN;
                end
            end
            S_LOOKUP: begin
                if (lookup_s == NE) begin
                    path_err_d = 1'b1;
                    state_d    = S_ERROR;
                end else begin
                    next_node_d  = lookup_s;
                    next_valid_d = 1'b1;
                    state_d      = S_WAIT_ARRIVE;
                end
            end
            S_WAIT_ARRIVE: begin
                if (node_flag) begin
                    pos_d        = next_node_q;
                    next_valid_d = 1'b0;
                    push_s       = 1'b1;
                    push_data_s  = next_node_q;
                    state_d      = S_WAIT_TURN;
                end else begin
                    state_d = S_WAIT_ARRIVE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;   // only reset leaves this state
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Log FIFO control: pop is decided first so a full FIFO can accept a push
    // in the same cycle it is read; the show-ahead head is precomputed here.
    always_comb begin
        do_pop_s  = log_rd & (count_q != 6'd0);
        do_push_s = push_s & ((count_q != DEPTH_CNT) | do_pop_s);
        rd_d      = do_pop_s  ? ptr_inc(rd_q) : rd_q;
        wr_d      = do_push_s ? ptr_inc(wr_q) : wr_q;
        count_d   = count_q + {5'd0, do_push_s} - {5'd0, do_pop_s};
        empty_d   = (count_d == 6'd0);
        full_d    = (count_d == DEPTH_CNT);
        if (do_push_s && (rd_d == wr_q)) begin
            log_data_d = push_data_s;       // new entry becomes the head
        end else begin
            log_data_d = mem_q[rd_d];
        end
    end

    // State and FIFO bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk_3125KHz) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pos_q        <= START_NODE;
            hdg_q        <= START_HDG;
            next_node_q  <= 5'd0;
            next_valid_q <= 1'b0;
            path_err_q   <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= 6'd0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            log_data_q   <= 5'd0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            hdg_q        <= hdg_d;
            next_node_q  <= next_node_d;
            next_valid_q <= next_valid_d;
            path_err_q   <= path_err_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            log_data_q   <= log_data_d;
        end
    end

    // Log storage; contents are left as-is across reset.
    always_ff @(posedge clk_3125KHz) begin
        if (do_push_s) begin
            mem_q[wr_q] <= push_data_s;
        end
    end

    assign realtime_pos = pos_q;
    assign heading      = hdg_q;
    assign next_node    = next_node_q;
    assign next_valid   = next_valid_q;
    assign path_err     = path_err_q;
    assign log_data     = log_data_q;
    assign log_empty    = empty_q;
    assign log_full     = full_q;
    assign log_count    = count_q;

endmodule

// File: tb/tb_turn_decoder.sv
// Self-checking bench for turn_decoder: directed scenarios plus a random walk
// compared against a graph/queue reference model.
module tb_turn_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       CPU_start, turn_valid, node_flag, log_rd;
    logic [1:0] turn_taken;
    logic [4:0] realtime_pos, next_node, log_data;
    logic [1:0] heading;
    logic       next_valid, path_err, log_empty, log_full;
    logic [5:0] log_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: arena graph, bot position/heading, visited-node log.
    int adj_m [30][4];
    int m_pos, m_hdg, m_dest;
    bit m_err;
    int logq [$];

    turn_decoder dut (
        .clk_3125KHz (clk),
        .rst_n       (rst_n),
        .CPU_start   (CPU_start),
        .turn_valid  (turn_valid),
        .turn_taken  (turn_taken),
        .node_flag   (node_flag),
        .log_rd      (log_rd),
        .realtime_pos(realtime_pos),
        .heading     (heading),
        .next_node   (next_node),
        .next_valid  (next_valid),
        .path_err    (path_err),
        .log_data    (log_data),
        .log_empty   (log_empty),
        .log_full    (log_full),
        .log_count   (log_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bidirectional road: a->b heading d, b->a heading d+2.
    task automatic connect(input int a, input int d, input int b);
        adj_m[a][d]           = b;
        adj_m[b][(d + 2) % 4] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 32'(log_count), logq.size());
        check({tag, "_empty"}, 32'(log_empty), 32'(logq.size() == 0));
        check({tag, "_full"},  32'(log_full),  32'(logq.size() == 32));
        if (logq.size() > 0) check({tag, "_data"}, 32'(log_data), logq[0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; CPU_start = 1'b0; turn_valid = 1'b0; node_flag = 1'b0;
        log_rd = 1'b0; turn_taken = 2'd0;
        tick();
        check("rst_pos", 32'(realtime_pos), 0);
        check("rst_hdg", 32'(heading), 0);
        check("rst_next_node", 32'(next_node), 0);
        check("rst_next_valid", 32'(next_valid), 0);
        check("rst_path_err", 32'(path_err), 0);
        check("rst_log_count", 32'(log_count), 0);
        check("rst_log_empty", 32'(log_empty), 1);
        check("rst_log_full", 32'(log_full), 0);
        check("rst_log_data", 32'(log_data), 0);
        rst_n = 1'b1;
        tick();
        m_pos = 0; m_hdg = 0; m_err = 1'b0;
        logq.delete();
    endtask

    task automatic do_start();
        CPU_start = 1'b1;
        tick();
        CPU_start = 1'b0;
        m_pos = 0; m_hdg = 0;
        logq.push_back(0);
        check("start_pos", 32'(realtime_pos), m_pos);
        check("start_hdg", 32'(heading), m_hdg);
        check_log("start");
    endtask

    task automatic turn_step(input int t);
        turn_taken = 2'(t);
        turn_valid = 1'b1;
        tick();
        turn_valid = 1'b0;
        m_hdg = (m_hdg + t) % 4;
        check("turn_hdg", 32'(heading), m_hdg);
        check("turn_nv_early", 32'(next_valid), 0);
        tick();
        m_dest = adj_m[m_pos][m_hdg];
        if (m_dest == 31) begin
            m_err = 1'b1;
            check("dead_path_err", 32'(path_err), 1);
            check("dead_next_valid", 32'(next_valid), 0);
        end else begin
            check("turn_next_valid", 32'(next_valid), 1);
            check("turn_next_node", 32'(next_node), m_dest);
            check("turn_path_err", 32'(path_err), 0);
        end
    endtask

    task automatic arrive(input bit rd);
        node_flag = 1'b1;
        log_rd    = rd;
        tick();
        node_flag = 1'b0;
        log_rd    = 1'b0;
        if (rd && logq.size() > 0) void'(logq.pop_front());
        if (logq.size() < 32) logq.push_back(m_dest);
        m_pos = m_dest;
        check("arr_pos", 32'(realtime_pos), m_pos);
        check("arr_next_valid", 32'(next_valid), 0);
        check_log("arr");
    endtask

    task automatic pop_one();
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
        if (logq.size() > 0) void'(logq.pop_front());
        check_log("pop");
    endtask

    // Pick a turn that leads to a real edge (U-turn always does after arrival).
    function automatic int safe_turn();
        int t;
        for (int k = 0; k < 16; k++) begin
            t = int'($urandom_range(0, 3));
            if (adj_m[m_pos][(m_hdg + t) % 4] != 31) return t;
        end
        return 2;
    endfunction

    initial begin
        for (int n = 0; n < 30; n++)
            for (int d = 0; d < 4; d++) adj_m[n][d] = 31;
        for (int n = 0; n < 9; n++) connect(n, 0, n + 1);
        connect(1, 1, 29);
        connect(29, 0, 20);
        for (int n = 9; n < 19; n++) connect(n, 1, n + 1);
        connect(19, 0, 28);
        for (int n = 20; n < 28; n++) connect(n, 1, n + 1);

        // Reset and straight start
        do_reset();
        do_start();
        turn_step(0);
        check("straight_next", 32'(next_node), 1);
        arrive(1'b0);

        // Turn wrap: right to E (29), then left back to N (20)
        turn_step(1);
        check("wrap_hdg_e", 32'(heading), 1);
        arrive(1'b0);
        turn_step(3);
        check("wrap_hdg_n", 32'(heading), 0);
        check_log("wrap_before_arrive");
        arrive(1'b0);

        // Ignored inputs: node_flag in WAIT_TURN, turn_valid/CPU_start in WAIT_ARRIVE
        node_flag = 1'b1; tick(); node_flag = 1'b0;
        check("ign_nf_pos", 32'(realtime_pos), m_pos);
        check("ign_nf_hdg", 32'(heading), m_hdg);
        check_log("ign_nf");
        turn_step(1);
        turn_valid = 1'b1; turn_taken = 2'd2; CPU_start = 1'b1; tick();
        turn_valid = 1'b0; CPU_start = 1'b0;
        check("ign_tv_hdg", 32'(heading), m_hdg);
        check("ign_tv_pos", 32'(realtime_pos), m_pos);
        check("ign_tv_nv", 32'(next_valid), 1);
        check_log("ign_tv");
        arrive(1'b0);

        // Drain in visit order, then a read while empty
        while (logq.size() > 0) pop_one();
        pop_one();

        // FIFO bounds: 33 arrivals with no reads, then read + arrival when full
        for (int i = 0; i < 33; i++) begin
            turn_step(safe_turn());
            arrive(1'b0);
        end
        check("bound_full", 32'(log_full), 1);
        check("bound_count", 32'(log_count), 32);
        turn_step(safe_turn());
        arrive(1'b1);
        check("bound_rdwr_count", 32'(log_count), 32);
        while (logq.size() > 0) pop_one();

        // Dead end: node 0 heading N, U-turn faces S with no road
        do_reset();
        do_start();
        turn_step(2);
        check("dead_hdg", 32'(heading), 2);
        turn_valid = 1'b1; turn_taken = 2'd1; node_flag = 1'b1; CPU_start = 1'b1;
        tick();
        turn_valid = 1'b0; node_flag = 1'b0; CPU_start = 1'b0;
        tick();
        check("stuck_hdg", 32'(heading), 2);
        check("stuck_pos", 32'(realtime_pos), 0);
        check("stuck_err", 32'(path_err), 1);
        check("stuck_nv", 32'(next_valid), 0);
        check_log("stuck");
        pop_one();

        // Mid-operation reset while a destination is pending
        do_reset();
        do_start();
        turn_step(0);
        do_reset();

        // Random walk with random reads; dead ends restart the run
        do_start();
        for (int i = 0; i < 150; i++) begin
            turn_step(int'($urandom_range(0, 3)));
            if (m_err) begin
                do_reset();
                do_start();
            end else begin
                arrive(1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/turn_decoder.md
TURN_DECODER -- requirements
Module: turn_decoder

Interface
REQ-001 Parameters: START_NODE, default 5'd0, node the bot sits on at start; START_HDG, default 2'd0, initial absolute heading (0=N, 1=E, 2=S, 3=W); LOG_DEPTH, default 32, visited-node log entries.
REQ-002 clk_3125KHz  in  1  sole clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 CPU_start  in  1  single-cycle pulse; starts tracking from START_NODE/START_HDG.
REQ-005 turn_valid  in  1  single-cycle strobe: turn_taken holds the turn executed at the current node.
REQ-006 turn_taken  in  2  relative turn: 0 straight, 1 right, 2 U-turn, 3 left.
REQ-007 node_flag  in  1  single-cycle pulse: bot has arrived at the next node.
REQ-008 log_rd  in  1  pops one log entry when log_empty=0.
REQ-009 realtime_pos  out  5  node currently occupied.
REQ-010 heading  out  2  current absolute heading.
REQ-011 next_node  out  5  decoded destination; valid only while next_valid=1.
REQ-012 next_valid  out  1  high from the completed lookup until arrival.
REQ-013 path_err  out  1  sticky; the turn led to no edge.
REQ-014 log_data  out  5  head of the visited-node FIFO (show-ahead).
REQ-015 log_empty, log_full  out  1 each  FIFO status.
REQ-016 log_count  out  6  entries held, 0..LOG_DEPTH.

Function
REQ-017 The block SHALL hold the fixed 30-node arena adjacency constant, four 5-bit fields per node (N,E,S,W), with 5'd31 meaning no edge; it is the inverse of the turn encoder: heading plus turn gives next node.
REQ-018 FSM states: IDLE, WAIT_TURN, LOOKUP, WAIT_ARRIVE, ERROR.
REQ-019 IDLE: on CPU_start, load realtime_pos=START_NODE and heading=START_HDG, push START_NODE to the log, and go to WAIT_TURN.
REQ-020 WAIT_TURN: on turn_valid, register heading <= (heading + turn_taken) mod 4 (2-bit wrap), then go to LOOKUP.
REQ-021 LOOKUP, one cycle: read adjacency[realtime_pos][heading].
  - If the entry is 31: set path_err and go to ERROR.
  - Otherwise: load next_node, set next_valid, and go to WAIT_ARRIVE.
  - Latency: next_valid rises 2 cycles after the turn_valid edge.
REQ-022 WAIT_ARRIVE: on node_flag, set realtime_pos <= next_node, clear next_valid, push next_node to the log, and return to WAIT_TURN in the same cycle.
REQ-023 Ignored inputs:
  - turn_valid outside WAIT_TURN.
  - node_flag outside WAIT_ARRIVE.
  - CPU_start outside IDLE.
REQ-024 ERROR: hold all outputs; leave only via reset. The log stays readable.
REQ-025 Log FIFO: circular buffer of LOG_DEPTH entries with wrapping read and write pointers.
  - log_count = writes minus reads.
  - log_full when log_count = LOG_DEPTH; log_empty when log_count = 0.
REQ-026 A push while full SHALL be dropped and SHALL NOT alter pointers; tracking continues.
REQ-027 A pop while empty SHALL be ignored.
REQ-028 Simultaneous push and pop when neither full nor empty: both pointers advance, log_count is unchanged.
REQ-029 Simultaneous push and pop when full: the pop is performed, then the push is performed.
REQ-030 Simultaneous push and pop when empty: only the push is performed, and log_data shows it the next cycle.
REQ-031 log_data SHALL equal mem[rd_ptr] registered, valid whenever log_empty=0.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL be in reset; the outputs take their reset values at the first clock edge with rst_n=0:
  - FSM=IDLE.
  - realtime_pos=START_NODE, heading=START_HDG.
  - next_node=0, next_valid=0, path_err=0.
  - Pointers=0, log_count=0, log_empty=1, log_full=0, log_data=0.
REQ-033 Reset mid-operation SHALL discard the in-flight turn and all log contents; log memory contents need no clearing.

Verification
REQ-034 Straight start: reset, CPU_start, turn_valid with turn 0 -> next_node=1 and next_valid=1 two cycles later; node_flag -> realtime_pos=1; log holds 0,1.
REQ-035 Turn wrap: at node 1 heading N, turn 1 -> heading=E, next_node=29; then turn 3 -> heading=N, next_node=20; after arrival log_count=3 (0,1,29 before 20 arrives).
REQ-036 Dead end: at node 0 heading N, turn 2 -> heading=S, adjacency is 31 -> path_err=1, FSM stuck; further turn_valid/node_flag change nothing.
REQ-037 Ignored inputs: node_flag in WAIT_TURN and turn_valid in WAIT_ARRIVE -> realtime_pos, heading and log_count unchanged.
REQ-038 FIFO bounds: 33 arrivals with no reads -> log_full=1, log_count=32, and entry 33 dropped; then log_rd with a simultaneous arrival -> count stays 32.
REQ-039 FIFO empty edge: a log_rd while empty has no effect; draining all entries returns them in visit order, then log_empty=1.
REQ-040 Mid-operation reset: rst_n=0 while next_valid=1 -> all outputs at their REQ-032 reset values from the next edge.
